fft_r2_sdf_stage: RTL and testbench

- One radix-2 decimation-in-time butterfly stage in single-path delay-feedback (SDF) form.
- Sits directly downstream of the bit-reversal core and consumes its bit-reversed complex sample stream over the same valid/ready handshake.
- Chaining K instances with STAGE = 0..K-1 forms a streaming N-point FFT.
- Each stage has an internal delay FIFO of depth 2^STAGE and produces its outputs in the same order as its inputs.

---
 rtl/fft_pkg.sv | 67 ++++++
 rtl/cplx_mul_round.sv | 32 +++
 rtl/fft_r2_sdf_stage.sv | 191 +++++++++++++++++++
 tb/tb_fft_r2_sdf_stage.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and elaboration-time twiddle generation for the radix-2 SDF FFT stages.
package fft_pkg;

    localparam int DW_DEF = 32;
    localparam int TW_DEF = 16;
    localparam real PI = 3.14159265358979323846;

    typedef struct packed {
        logic signed [DW_DEF/2-1:0] re;
        logic signed [DW_DEF/2-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [TW_DEF-1:0] re;
        logic signed [TW_DEF-1:0] im;
    } twiddle_t;

    typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;

    // Power series over [0, pi) keeps the table free of math-library calls at elaboration.
    function automatic real sin_r(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int n = 1; n < 24; n++) begin
            term = -term * x * x / (real'(2 * n) * real'(2 * n + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    function automatic real cos_r(input real x);
        real term;
        real sum;
        term = 1.0;
        sum  = 1.0;
        for (int n = 1; n < 24; n++) begin
            term = -term * x * x / (real'(2 * n - 1) * real'(2 * n));
            sum  = sum + term;
        end
        return sum;
    endfunction

    function automatic int quant(input real v, input int tw);
        real s;
        int  r;
        int  lim;
        lim = (1 << (tw - 1)) - 1;
        s   = v * real'(lim + 1);
        if (s >= 0.0) r = $rtoi(s + 0.5);
        else          r = -$rtoi(0.5 - s);
        if (r > lim)      r = lim;
        if (r < -lim - 1) r = -lim - 1;
        return r;
    endfunction

    // W(m) = exp(-j*pi*m/d), quantised to Q1.(tw-1).
    function automatic int tw_re(input int m, input int d, input int tw);
        return quant(cos_r(PI * real'(m) / real'(d)), tw);
    endfunction

    function automatic int tw_im(input int m, input int d, input int tw);
        return quant(-sin_r(PI * real'(m) / real'(d)), tw);
    endfunction

endpackage

// File: rtl/cplx_mul_round.sv
// Complex multiply of a sample by a Q1.(TW-1) twiddle, rounded half-up back to sample scale.
module cplx_mul_round #(
    parameter int HW = 16,
    parameter int TW = 16
) (
    input  logic signed [HW-1:0] b_re,
    input  logic signed [HW-1:0] b_im,
    input  logic signed [TW-1:0] w_re,
    input  logic signed [TW-1:0] w_im,
    output logic signed [HW:0]   p_re,
    output logic signed [HW:0]   p_im
);

    localparam int PW = HW + TW + 1;
    localparam logic signed [PW-1:0] RND = PW'(1) << (TW - 2);

    logic signed [PW-1:0] br, bi, wr, wi;
    logic signed [PW-1:0] acc_re, acc_im;

    assign br = PW'(b_re);
    assign bi = PW'(b_im);
    assign wr = PW'(w_re);
    assign wi = PW'(w_im);

    assign acc_re = br * wr - bi * wi + RND;
    assign acc_im = br * wi + bi * wr + RND;

    // |W| <= 1 keeps the rescaled product within one guard bit of the sample width.
    assign p_re = (HW + 1)'(acc_re >>> (TW - 1));
    assign p_im = (HW + 1)'(acc_im >>> (TW - 1));

endmodule

// File: rtl/fft_r2_sdf_stage.sv
// One radix-2 DIT butterfly stage in single-path delay-feedback form, natural-order output.
module fft_r2_sdf_stage
    import fft_pkg::*;
#(
    parameter int K     = 10,
    parameter int DW    = 32,
    parameter int STAGE = 0,
    parameter int TW    = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    input  logic          ready_i
);

    localparam int HW = DW / 2;
    localparam int D  = 1 << STAGE;
    localparam int N  = 1 << K;
    localparam int AW = (STAGE > 0) ? STAGE : 1;
    localparam logic signed [HW+1:0] MAXV = (HW + 2)'((1 << (HW - 1)) - 1);
    localparam logic signed [HW+1:0] MINV = -(HW + 2)'(1 << (HW - 1));

    state_t        state;
    logic [K-1:0]  cnt;
    logic [DW-1:0] mem [D];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW-1:0] m_idx;
    logic          half;

    logic          loadable, in_fire;
    logic          push, pop, load;
    logic [DW-1:0] push_data, load_data, head;

    logic signed [HW-1:0] a_re, a_im, b_re, b_im;
    logic signed [HW:0]   p_re, p_im, wb_re, wb_im;
    logic signed [HW+1:0] sum_re, sum_im, dif_re, dif_im;
    logic [DW-1:0]        bf_a, bf_b;
    logic signed [TW-1:0] tw_re_rom [D];
    logic signed [TW-1:0] tw_im_rom [D];

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(D - 1)) ? '0 : p + AW'(1);
    endfunction

    function automatic logic [HW-1:0] scale_sat(input logic signed [HW+1:0] v);
        logic signed [HW+1:0] s;
        s = v >>> 1;
        if (s > MAXV) s = MAXV;
        if (s < MINV) s = MINV;
        return s[HW-1:0];
    endfunction

    for (genvar g = 0; g < D; g++) begin : g_tw
        localparam int WR = tw_re(g, D, TW);
        localparam int WI = tw_im(g, D, TW);
        assign tw_re_rom[g] = WR[TW-1:0];
        assign tw_im_rom[g] = WI[TW-1:0];
    end

    assign half = cnt[STAGE];
    if (STAGE == 0) begin : g_m0
        assign m_idx = '0;
    end else begin : g_m
        assign m_idx = cnt[STAGE-1:0];
    end

    assign head = mem[rd_ptr];
    assign a_re = head[DW-1:HW];
    assign a_im = head[HW-1:0];
    assign b_re = data_i[DW-1:HW];
    assign b_im = data_i[HW-1:0];

    cplx_mul_round #(.HW(HW), .TW(TW)) u_mul (
        .b_re (b_re),
        .b_im (b_im),
        .w_re (tw_re_rom[m_idx]),
        .w_im (tw_im_rom[m_idx]),
        .p_re (p_re),
        .p_im (p_im)
    );

    // m = 0 is W = 1, which is not representable in Q1.(TW-1), so the multiplier is bypassed.
    assign wb_re = (m_idx == '0) ? (HW + 1)'(b_re) : p_re;
    assign wb_im = (m_idx == '0) ? (HW + 1)'(b_im) : p_im;

    assign sum_re = (HW + 2)'(a_re) + (HW + 2)'(wb_re);
    assign sum_im = (HW + 2)'(a_im) + (HW + 2)'(wb_im);
    assign dif_re = (HW + 2)'(a_re) - (HW + 2)'(wb_re);
    assign dif_im = (HW + 2)'(a_im) - (HW + 2)'(wb_im);
    assign bf_a   = {scale_sat(sum_re), scale_sat(sum_im)};
    assign bf_b   = {scale_sat(dif_re), scale_sat(dif_im)};

    // Handshake: a transfer happens on a clock edge where valid and ready are both high;
    // valid_o/data_o stay constant until that edge, and ready_o never waits on valid_i.
    assign loadable = !valid_o || ready_i;

    always_comb begin
        ready_o = 1'b0;
        case (state)
            FILL:    ready_o = 1'b1;
            RUN:     ready_o = loadable;
            default: ready_o = 1'b0;
        endcase
    end

    assign in_fire = valid_i && ready_o;

    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        load      = 1'b0;
        push_data = data_i;
        load_data = head;
        case (state)
            FILL: push = in_fire;
            RUN: begin
                if (in_fire) begin
                    push = 1'b1;
                    pop  = 1'b1;
                    load = 1'b1;
                    if (half) begin
                        load_data = bf_a;
                        push_data = bf_b;
                    end
                end
            end
            DRAIN: begin
                if (loadable) begin
                    pop  = 1'b1;
                    load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= FILL;
            cnt     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            if (load) begin
                valid_o <= 1'b1;
                data_o  <= load_data;
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
            case (state)
                FILL: begin
                    if (in_fire) begin
                        cnt <= cnt + K'(1);
                        if (cnt == K'(D - 1)) state <= RUN;
                    end
                end
                RUN: begin
                    if (in_fire) begin
                        cnt <= cnt + K'(1);
                        if (cnt == K'(N - 1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // cnt restarts at 0 on frame wrap and doubles as the drain pop counter.
                    if (loadable) begin
                        if (cnt == K'(D - 1)) begin
                            cnt   <= '0;
                            state <= FILL;
                        end else begin
                            cnt <= cnt + K'(1);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_r2_sdf_stage.sv
// Bench for fft_r2_sdf_stage: four stage configurations checked against a frame-level butterfly model.
module tb_fft_r2_sdf_stage;

    localparam int NI = 4;
    localparam int KS [NI] = '{3, 3, 4, 3};
    localparam int STG[NI] = '{0, 1, 2, 2};
    localparam real PI = 3.14159265358979323846;
    localparam int MAX_CYC = 4000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vin  [NI];
    logic [31:0] din  [NI];
    logic        rin  [NI];
    logic        rout [NI];
    logic        vout [NI];
    logic [31:0] dout [NI];

    logic [31:0] in_q[$];
    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft_r2_sdf_stage #(.K(3), .DW(32), .STAGE(0), .TW(16)) u0 (
        .clk_i(clk), .rst_i(rst), .valid_i(vin[0]), .data_i(din[0]), .ready_o(rout[0]),
        .valid_o(vout[0]), .data_o(dout[0]), .ready_i(rin[0]));
    fft_r2_sdf_stage #(.K(3), .DW(32), .STAGE(1), .TW(16)) u1 (
        .clk_i(clk), .rst_i(rst), .valid_i(vin[1]), .data_i(din[1]), .ready_o(rout[1]),
        .valid_o(vout[1]), .data_o(dout[1]), .ready_i(rin[1]));
    fft_r2_sdf_stage #(.K(4), .DW(32), .STAGE(2), .TW(16)) u2 (
        .clk_i(clk), .rst_i(rst), .valid_i(vin[2]), .data_i(din[2]), .ready_o(rout[2]),
        .valid_o(vout[2]), .data_o(dout[2]), .ready_i(rin[2]));
    fft_r2_sdf_stage #(.K(3), .DW(32), .STAGE(2), .TW(16)) u3 (
        .clk_i(clk), .rst_i(rst), .valid_i(vin[3]), .data_i(din[3]), .ready_o(rout[3]),
        .valid_o(vout[3]), .data_o(dout[3]), .ready_i(rin[3]));

    // ---------------- reference model ----------------
    function automatic logic [31:0] cpx(input int re, input int im);
        return {re[15:0], im[15:0]};
    endfunction

    function automatic logic [15:0] sat16(input longint v);
        longint c;
        c = v;
        if (c > 32767)  c = 32767;
        if (c < -32768) c = -32768;
        return c[15:0];
    endfunction

    function automatic longint qtw(input real v);
        real s;
        longint r;
        s = v * 32768.0;
        if (s >= 0.0) r = longint'($rtoi(s + 0.5));
        else          r = -longint'($rtoi(0.5 - s));
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    function automatic void bfly(input logic [31:0] a, input logic [31:0] b, input int m, input int d,
                                 output logic [31:0] ra, output logic [31:0] rb);
        longint ar, ai, br, bi, wr, wi, pr, pq;
        real ang;
        ar = longint'($signed(a[31:16]));
        ai = longint'($signed(a[15:0]));
        br = longint'($signed(b[31:16]));
        bi = longint'($signed(b[15:0]));
        if (m == 0) begin
            pr = br;
            pq = bi;
        end else begin
            ang = PI * real'(m) / real'(d);
            wr  = qtw($cos(ang));
            wi  = qtw(-$sin(ang));
            pr  = (wr * br - wi * bi + 16384) >>> 15;
            pq  = (wr * bi + wi * br + 16384) >>> 15;
        end
        ra = {sat16((ar + pr) >>> 1), sat16((ai + pq) >>> 1)};
        rb = {sat16((ar - pr) >>> 1), sat16((ai - pq) >>> 1)};
    endfunction

    // Whole-frame butterfly: pair x[p+m] with x[p+D+m], emit all sums then all differences per block.
    task automatic model_frame(input int k, input int st, input logic [31:0] f[$]);
        int n, d;
        logic [31:0] ra, rb;
        logic [31:0] bq[$];
        n = 1 << k;
        d = 1 << st;
        for (int p = 0; p < n; p += 2 * d) begin
            bq.delete();
            for (int m = 0; m < d; m++) begin
                bfly(f[p + m], f[p + d + m], m, d, ra, rb);
                exp_q.push_back(ra);
                bq.push_back(rb);
            end
            for (int m = 0; m < d; m++) exp_q.push_back(bq[m]);
        end
    endtask

    task automatic add_random_frames(input int inst, input int frames);
        logic [31:0] f[$];
        for (int fr = 0; fr < frames; fr++) begin
            f.delete();
            for (int i = 0; i < (1 << KS[inst]); i++) f.push_back($urandom());
            model_frame(KS[inst], STG[inst], f);
            for (int i = 0; i < f.size(); i++) in_q.push_back(f[i]);
        end
    endtask

    // ---------------- clock / reset / driver ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            vin[i] = 1'b0;
            din[i] = '0;
            rin[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_stream(input int inst, input int duty, input string name, output int stall_in);
        int cyc;
        logic hold_chk;
        logic [31:0] held;
        logic [31:0] e;
        cyc = 0;
        hold_chk = 1'b0;
        held = '0;
        stall_in = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < MAX_CYC) begin
            @(negedge clk);
            vin[inst] = (in_q.size() > 0);
            din[inst] = (in_q.size() > 0) ? in_q[0] : '0;
            rin[inst] = ($urandom_range(99) < duty);
            #1;
            if (hold_chk) begin
                checks++;
                if (vout[inst] !== 1'b1 || dout[inst] !== held) begin
                    errors++;
                    $display("FAIL %s_hold: valid=%b data=%h, required valid=1 data=%h", name, vout[inst], dout[inst], held);
                end
            end
            if (vout[inst] === 1'b1 && rin[inst]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_extra: output %h with nothing expected", name, dout[inst]);
                end else begin
                    e = exp_q.pop_front();
                    if (dout[inst] !== e) begin
                        errors++;
                        $display("FAIL %s_data: got %h, required %h", name, dout[inst], e);
                    end
                end
            end
            hold_chk = (vout[inst] === 1'b1) && !rin[inst];
            held = dout[inst];
            if (vin[inst] && rout[inst] === 1'b1) void'(in_q.pop_front());
            else if (vin[inst]) stall_in++;
            cyc++;
        end
        @(negedge clk);
        vin[inst] = 1'b0;
        rin[inst] = 1'b1;
        if (cyc >= MAX_CYC) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d inputs and %0d outputs left after %0d cycles", name, in_q.size(), exp_q.size(), cyc);
            in_q.delete();
            exp_q.delete();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (vout[i] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b, required 0", i, vout[i]); end
            checks++;
            if (dout[i] !== 32'h0) begin errors++; $display("FAIL reset_data[%0d]: got %h, required 0", i, dout[i]); end
            checks++;
            if (rout[i] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d]: got %b, required 1", i, rout[i]); end
        end
    endtask

    task automatic test_butterfly();
        int xin[8] = '{4, 2, 0, 0, 6, -2, 1, 1};
        int xout[8] = '{3, 1, 0, 0, 2, 4, 1, 0};
        int st;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_q.push_back(cpx(xin[i], 0));
            exp_q.push_back(cpx(xout[i], 0));
        end
        add_random_frames(0, 1);
        run_stream(0, 100, "butterfly", st);
        checks++;
        if (st != 1) begin errors++; $display("FAIL butterfly_drain_gap: ready_o low %0d cycles, required 1", st); end
    endtask

    task automatic test_twiddle();
        int st;
        do_reset();
        in_q.push_back(cpx(8, 0));
        in_q.push_back(cpx(0, 0));
        in_q.push_back(cpx(2, 0));
        in_q.push_back(cpx(100, 0));
        for (int i = 0; i < 4; i++) in_q.push_back(cpx(0, 0));
        exp_q.push_back(cpx(5, 0));
        exp_q.push_back(cpx(0, -50));
        exp_q.push_back(cpx(3, 0));
        exp_q.push_back(cpx(0, 50));
        for (int i = 0; i < 4; i++) exp_q.push_back(cpx(0, 0));
        add_random_frames(1, 2);
        run_stream(1, 100, "twiddle", st);
    endtask

    task automatic test_rounding();
        int xin[8] = '{-2, -1, 32767, 32767, 0, 0, 0, 0};
        int xout[8] = '{-2, -1, 32767, 0, 0, 0, 0, 0};
        int st;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_q.push_back(cpx(xin[i], 0));
            exp_q.push_back(cpx(xout[i], 0));
        end
        run_stream(0, 100, "rounding", st);
    endtask

    task automatic test_backpressure();
        int st;
        do_reset();
        add_random_frames(2, 3);
        run_stream(2, 30, "backpressure", st);
    endtask

    task automatic test_reset_mid();
        int st;
        do_reset();
        rin[2] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vin[2] = 1'b1;
            din[2] = $urandom();
        end
        @(negedge clk);
        vin[2] = 1'b0;
        #1;
        checks++;
        if (vout[2] !== 1'b1) begin errors++; $display("FAIL midreset_pre_valid: got %b, required 1", vout[2]); end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (vout[2] !== 1'b0) begin errors++; $display("FAIL midreset_async_valid: got %b, required 0", vout[2]); end
        checks++;
        if (dout[2] !== 32'h0) begin errors++; $display("FAIL midreset_async_data: got %h, required 0", dout[2]); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rin[2] = 1'b1;
        add_random_frames(2, 1);
        run_stream(2, 100, "midreset", st);
        checks++;
        if (st != 0) begin errors++; $display("FAIL midreset_stall: ready_o low %0d cycles, required 0", st); end
    endtask

    task automatic test_back_to_back();
        int st;
        do_reset();
        add_random_frames(3, 2);
        run_stream(3, 100, "back_to_back", st);
        checks++;
        if (st != 4) begin errors++; $display("FAIL back_to_back_gap: ready_o low %0d cycles, required 4", st); end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            vin[i] = 1'b0;
            din[i] = '0;
            rin[i] = 1'b1;
        end
        test_reset();
        test_butterfly();
        test_twiddle();
        test_rounding();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
